// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready output buffer with frame-error and overrun pulses.
module uart_rx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CPB - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   if (CPB < 4) begin : g_cpb_chk
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
      $error("uart_rx: DATA_BITS must be in 5..8");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t        state;
   logic          rx_s1;
   logic          rxs;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   assign busy = (state != IDLE);

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state     <= IDLE;
         rx_s1     <= 1'b1;
         rxs       <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rxs       <= rx_s1;
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // A plain drain; a completing good frame below overrides it.
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxs)
                  state <= START;
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                     shreg   <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rxs;
                  if (bit_idx == LAST_BIT)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     // Load when empty or being drained this same cycle.
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_IDLE: begin
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB=16: directed scenarios plus random
// back-to-back bytes checked against an in-order queue of transmitted bytes.
module tb_uart_rx;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b1;
   logic       rx         = 1'b1;
   logic       rx_ready   = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] got_q[$];
   int   fe_cnt, ov_cnt, valid_hi, rise_cnt, last_rise, fall_cyc;
   logic prev_valid = 1'b0;

   uart_rx #(.CLK_FREQ(100_000_000), .BAUD(6_250_000), .DATA_BITS(8)) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   always @(posedge clk_100MHz) cyc++;

   // Observer: records consumed bytes and flag pulses between edges.
   always @(negedge clk_100MHz) begin
      if (!reset) begin
         if (rx_valid && !prev_valid) begin
            rise_cnt++;
            last_rise = cyc;
         end
         if (rx_valid) valid_hi++;
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         prev_valid = rx_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic clear_obs();
      got_q.delete();
      fe_cnt = 0; ov_cnt = 0; valid_hi = 0; rise_cnt = 0; last_rise = -1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_100MHz); #1;
         rx = 1'b1;
      end
   endtask

   // Drives the first ncyc cycles of a 10-bit frame, 16 clocks per bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncyc);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk_100MHz); #1;
         if (k == 0) fall_cyc = cyc;
         rx = fr[k / 16];
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx = 1'b0; rx_ready = 1'b1;
      repeat (2) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(posedge clk_100MHz); #1;
      rx = 1'b1;
      @(posedge clk_100MHz); #1;
      reset = 1'b0;
      idle(10);
      @(negedge clk_100MHz);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 160);
      idle(40);
      total++; if (last_rise - fall_cyc !== 155) begin bad++; $display("FAIL single_latency got=%0d exp=155", last_rise - fall_cyc); end
      total++; if (valid_hi !== 1) begin bad++; $display("FAIL single_valid_width got=%0d exp=1", valid_hi); end
      total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", got_q[0]); end
      end
      total++; if (fe_cnt !== 0 || ov_cnt !== 0) begin bad++; $display("FAIL single_flags got fe=%0d ov=%0d exp 0/0", fe_cnt, ov_cnt); end
   endtask

   task automatic test_loopback();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      clear_obs();
      rx_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, 1'b1, 160);
      end
      idle(60);
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL loop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL loop_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (fe_cnt !== 0 || ov_cnt !== 0) begin bad++; $display("FAIL loop_flags got fe=%0d ov=%0d exp 0/0", fe_cnt, ov_cnt); end
   endtask

   task automatic test_glitch();
      logic busy_seen, busy_at11;
      clear_obs();
      busy_seen = 1'b1;
      busy_at11 = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk_100MHz); #1;
         if (k == 0) fall_cyc = cyc;
         rx = (k < 4) ? 1'b0 : 1'b1;
         @(negedge clk_100MHz);
         if (k >= 3 && k <= 10 && busy !== 1'b1) busy_seen = 1'b0;
         if (k == 11) busy_at11 = busy;
      end
      total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=0 exp=1"); end
      total++; if (busy_at11 !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall got=%b exp=0", busy_at11); end
      total++; if (rise_cnt !== 0 || fe_cnt !== 0 || ov_cnt !== 0)
         begin bad++; $display("FAIL glitch_flags got v=%0d fe=%0d ov=%0d exp 0/0/0", rise_cnt, fe_cnt, ov_cnt); end
   endtask

   task automatic test_bad_stop();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0, 160);
      for (int k = 0; k < 100; k++) begin
         @(posedge clk_100MHz); #1;
         rx = 1'b0;
      end
      @(negedge clk_100MHz);
      total++; if (fe_cnt !== 1) begin bad++; $display("FAIL badstop_fe_pulse got=%0d exp=1", fe_cnt); end
      total++; if (rise_cnt !== 0) begin bad++; $display("FAIL badstop_valid got=%0d exp=0", rise_cnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL badstop_wait_busy got=%b exp=1", busy); end
      idle(20);
      send_frame(8'h11, 1'b1, 160);
      idle(40);
      total++; if (got_q.size() !== 1) begin bad++; $display("FAIL badstop_count got=%0d exp=1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== 8'h11) begin bad++; $display("FAIL badstop_next got=%h exp=11", got_q[0]); end
      end
      total++; if (fe_cnt !== 1) begin bad++; $display("FAIL badstop_fe_after got=%0d exp=1", fe_cnt); end
   endtask

   task automatic test_overrun();
      clear_obs();
      rx_ready = 1'b0;
      send_frame(8'h01, 1'b1, 160);
      send_frame(8'h02, 1'b1, 160);
      idle(40);
      @(negedge clk_100MHz);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
      total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL ovr_data got=%h exp=01", rx_data); end
      total++; if (ov_cnt !== 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); end
      @(posedge clk_100MHz); #1; rx_ready = 1'b1;
      @(posedge clk_100MHz); #1; rx_ready = 1'b0;
      @(negedge clk_100MHz);
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", rx_valid); end
      total++; if (got_q.size() !== 1 || got_q[0] !== 8'h01) begin bad++; $display("FAIL ovr_consumed got_n=%0d exp=1 byte 01", got_q.size()); end
   endtask

   task automatic test_drain_fill();
      clear_obs();
      rx_ready = 1'b0;
      send_frame(8'h01, 1'b1, 160);
      fork
         send_frame(8'h02, 1'b1, 160);
         begin
            repeat (155) @(posedge clk_100MHz);
            #1 rx_ready = 1'b1;
            @(posedge clk_100MHz);
            #1 rx_ready = 1'b0;
         end
      join
      idle(30);
      @(negedge clk_100MHz);
      total++; if (rx_data !== 8'h02) begin bad++; $display("FAIL dfill_data got=%h exp=02", rx_data); end
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL dfill_valid got=%b exp=1", rx_valid); end
      total++; if (ov_cnt !== 0) begin bad++; $display("FAIL dfill_overrun got=%0d exp=0", ov_cnt); end
      total++; if (rise_cnt !== 1) begin bad++; $display("FAIL dfill_valid_gap got=%0d exp=1", rise_cnt); end
      total++; if (got_q.size() !== 1 || got_q[0] !== 8'h01) begin bad++; $display("FAIL dfill_consumed got_n=%0d exp=1 byte 01", got_q.size()); end
      @(posedge clk_100MHz); #1; rx_ready = 1'b1;
      @(posedge clk_100MHz); #1;
   endtask

   task automatic test_reset_mid();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'($urandom) & 8'hEF, 1'b1, 88);
      @(negedge clk_100MHz);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
      @(posedge clk_100MHz); #1;
      reset = 1'b1; rx = 1'b1;
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      total++; if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000)
         begin bad++; $display("FAIL rmid_outputs got=%h/%b%b%b%b exp=00/0000", rx_data, rx_valid, frame_err, overrun, busy); end
      @(posedge clk_100MHz); #1;
      reset = 1'b0;
      idle(20);
      send_frame(8'h7E, 1'b1, 160);
      idle(40);
      total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== 8'h7E) begin bad++; $display("FAIL rmid_data got=%h exp=7e", got_q[0]); end
      end
      total++; if (fe_cnt !== 0) begin bad++; $display("FAIL rmid_fe got=%0d exp=0", fe_cnt); end
   endtask

   initial begin
      clear_obs();
      test_reset();
      test_single();
      test_loopback();
      test_glitch();
      test_bad_stop();
      test_overrun();
      test_drain_fill();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the serial `tx` line produced by the `demo` top level (8N1, LSB first, idle high).
- Deserialises each frame into a byte and presents it on a one-entry valid/ready output buffer.
- Used in the bench as the loopback checker, and on-board when the design also needs an RX path.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s. CPB = CLK_FREQ/BAUD (integer division); CPB must be ≥ 4, checked by an elaboration-time assertion.
- DATA_BITS, 8, data bits per frame (5..8). Unused upper bits of rx_data read 0.

Ports:
- clk_100MHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  8  received byte, valid while rx_valid=1.
- rx_valid  out  1  output buffer holds an unread byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while buffer full and not being drained.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (one clock with reset=1):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, counters=0, synchroniser flops=1.
- Reset mid-frame aborts the frame; no partial byte is ever emitted.
- Synchroniser: 2 flops on rx. rxs is the second flop output. All decisions use rxs only, so it lags the pin by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxs=0 → START, counter cleared. Call this cycle t0.
  - START: at t0+CPB/2, sample rxs.
    - rxs=1 → glitch; return to IDLE with no flags.
    - rxs=0 → DATA, bit index 0.
  - DATA: sample bit i at t0 + CPB/2 + (i+1)·CPB into shift register, LSB first. After bit DATA_BITS-1 → STOP.
  - STOP: sample at t0 + CPB/2 + (DATA_BITS+1)·CPB.
    - rxs=1 → frame good; go to IDLE.
    - rxs=0 → frame_err pulses on the next cycle, byte discarded; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then go to IDLE. This handles a break (line held low) without false restarts.
- Counter: a single CPB-range bit-timer plus a bit index; no fractional baud correction.
- Output buffer (good frame completes in cycle tc; effects appear at tc+1):
  - Buffer empty: rx_data←byte, rx_valid←1.
  - Buffer full and rx_ready=1 in cycle tc (simultaneous drain and fill): new byte loaded, rx_valid stays 1, no overrun.
  - Buffer full and rx_ready=0: overrun pulses one cycle, new byte dropped, old rx_data/rx_valid unchanged.
- Draining: rx_valid && rx_ready with no new byte completing → rx_valid←0 next cycle. rx_data holds its last value.
- rx_ready while rx_valid=0 has no effect.
- busy=0 only in IDLE.
- Back-to-back frames: a start edge present at the first IDLE cycle after STOP is accepted; no dead cycles are required.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=100_000_000, BAUD=6_250_000 (CPB=16).
- Single byte 0xA5, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5. Rising edge of rx_valid exactly 2+8+9·16+1 = 155 cycles after the pin falling edge. frame_err=0, overrun=0.
- Loopback with the `demo` DUT `tx` → `rx`: every byte transmitted after reset deasserts is received in order, with no frame_err.
- Glitch: rx low for 4 cycles in IDLE → busy rises then falls by t0+9. rx_valid, frame_err and overrun all stay 0.
- Bad stop: frame 0x3C with stop bit driven 0, then line held low 100 cycles → frame_err one-cycle pulse, rx_valid stays 0. No new frame starts until rx returns high, after which 0x11 is received correctly.
- Overrun: rx_ready=0, send 0x01 then 0x02 back-to-back → rx_valid=1, rx_data=0x01, overrun pulses once after the second frame. Asserting rx_ready for 1 cycle then clears rx_valid.
- Simultaneous drain and fill: rx_ready=1 asserted exactly in the stop-bit completion cycle of 0x02 while 0x01 is buffered → rx_data=0x02, rx_valid stays 1, no overrun.
- Reset mid-frame: reset asserted during data bit 4 → all outputs 0 next cycle. A following clean frame 0x7E is received correctly.
